// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises instruction-fetch reads and LSU reads/writes onto one BRAM.
// Define RAM_ARB_RR_EN for round-robin tie-breaking; otherwise the LSU always wins ties.
module ram_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ram_rd_en,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_addr_rd,
    output logic [ADDR_W-1:0] ram_addr_wr,
    output logic [DATA_W-1:0] ram_data_wr,
    input  logic [DATA_W-1:0] ram_data_rd,
    output logic              busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] RDATA = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    logic [1:0]        state, state_nx;
    // Last granted requester (1 = LSU); also routes returning read data.
    logic              owner_ls, owner_ls_nx;
    logic              pick_ls;
    logic              if_gnt_nx, ls_gnt_nx, if_rvalid_nx, ls_rvalid_nx;
    logic              rd_en_nx, wr_en_nx, busy_nx;
    logic [DATA_W-1:0] if_rdata_nx, ls_rdata_nx, data_wr_nx;
    logic [ADDR_W-1:0] addr_rd_nx, addr_wr_nx;

`ifdef RAM_ARB_RR_EN
    assign pick_ls = ls_req & (~if_req | ~owner_ls);
`else
    assign pick_ls = ls_req;
`endif

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_nx     = state;
        owner_ls_nx  = owner_ls;
        if_gnt_nx    = 1'b0;
        ls_gnt_nx    = 1'b0;
        if_rvalid_nx = 1'b0;
        ls_rvalid_nx = 1'b0;
        rd_en_nx     = 1'b0;
        wr_en_nx     = 1'b0;
        if_rdata_nx  = if_rdata;
        ls_rdata_nx  = ls_rdata;
        addr_rd_nx   = ram_addr_rd;
        addr_wr_nx   = ram_addr_wr;
        data_wr_nx   = ram_data_wr;
        if (state == READ) begin
            state_nx = RDATA;
        end else begin
            if (state == RDATA) begin
                if (owner_ls) begin
                    ls_rdata_nx  = ram_data_rd;
                    ls_rvalid_nx = 1'b1;
                end else begin
                    if_rdata_nx  = ram_data_rd;
                    if_rvalid_nx = 1'b1;
                end
            end
            if (pick_ls) begin
                owner_ls_nx = 1'b1;
                ls_gnt_nx   = 1'b1;
                if (ls_we) begin
                    state_nx   = WRITE;
                    wr_en_nx   = 1'b1;
                    addr_wr_nx = ls_addr;
                    data_wr_nx = ls_wdata;
                end else begin
                    state_nx   = READ;
                    rd_en_nx   = 1'b1;
                    addr_rd_nx = ls_addr;
                end
            end else if (if_req) begin
                owner_ls_nx = 1'b0;
                if_gnt_nx   = 1'b1;
                state_nx    = READ;
                rd_en_nx    = 1'b1;
                addr_rd_nx  = if_addr;
            end else begin
                state_nx = IDLE;
            end
        end
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            owner_ls    <= 1'b0;
            if_gnt      <= 1'b0;
            ls_gnt      <= 1'b0;
            if_rvalid   <= 1'b0;
            ls_rvalid   <= 1'b0;
            if_rdata    <= '0;
            ls_rdata    <= '0;
            ram_rd_en   <= 1'b0;
            ram_wr_en   <= 1'b0;
            ram_addr_rd <= '0;
            ram_addr_wr <= '0;
            ram_data_wr <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            owner_ls    <= owner_ls_nx;
            if_gnt      <= if_gnt_nx;
            ls_gnt      <= ls_gnt_nx;
            if_rvalid   <= if_rvalid_nx;
            ls_rvalid   <= ls_rvalid_nx;
            if_rdata    <= if_rdata_nx;
            ls_rdata    <= ls_rdata_nx;
            ram_rd_en   <= rd_en_nx;
            ram_wr_en   <= wr_en_nx;
            ram_addr_rd <= addr_rd_nx;
            ram_addr_wr <= addr_wr_nx;
            ram_data_wr <= data_wr_nx;
            busy        <= busy_nx;
        end
    end
endmodule
